ahb_buzzer_ctrl: RTL and testbench

//  AHB-Lite slave that lets the Cortex-M0 select and launch tunes on the Buzzermusic player.

---
 rtl/ahb_buzzer_ctrl.sv | 159 +++++++++++++++
 tb/tb_ahb_buzzer_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_buzzer_ctrl.sv
// AHB-Lite slave that selects and launches tunes on the Buzzermusic player.
// Tracks play state, counts completed tunes and raises a level IRQ on completion.
module ahb_buzzer_ctrl #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [1:0]        music_select,
  output logic              music_start,
  input  logic              music_finish,
  output logic              irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 2;

  localparam logic [IDX_W-1:0] A_CTRL    = IDX_W'(0);
  localparam logic [IDX_W-1:0] A_STATUS  = IDX_W'(1);
  localparam logic [IDX_W-1:0] A_PLAYCNT = IDX_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KICK = 2'd1,
    ST_ARM  = 2'd2,
    ST_PLAY = 2'd3
  } state_t;

  state_t             state;
  logic               dp_valid;
  logic               dp_write;
  logic [IDX_W-1:0]   dp_addr;
  logic [SEL_W-1:0]   sel_q;
  logic               irq_en_q;
  logic               done_q;
  logic               ovr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   music_select_q;
  logic               music_start_q;
  logic               irq_q;

  logic               wr_commit;
  logic               wr_ctrl;
  logic               wr_status;
  logic               start_req;
  logic               busy;
  logic               finish_evt;
  logic               start_ok;
  logic [SEL_W-1:0]   sel_n;
  logic               irq_en_n;
  logic               done_n;
  logic               ovr_n;
  logic [DATA_W-1:0]  rd_data;
  logic               unused_bits;

  assign HREADYOUT    = 1'b1;
  assign HRESP        = 1'b0;
  assign music_select = music_select_q;
  assign music_start  = music_start_q;
  assign irq          = irq_q;

  assign unused_bits = ^{HSIZE, HADDR[ADDR_W-1:4], HADDR[1:0], HWDATA[DATA_W-1:4]};

  // Write decode for the data phase currently completing
  assign wr_commit  = dp_valid & dp_write & HREADY;
  assign wr_ctrl    = wr_commit & (dp_addr == A_CTRL);
  assign wr_status  = wr_commit & (dp_addr == A_STATUS);
  assign start_req  = wr_ctrl & HWDATA[0];
  assign busy       = (state != ST_IDLE);
  assign finish_evt = (state == ST_PLAY) & music_finish;
  assign start_ok   = start_req & ~busy;

  // Next register values; hardware set beats software W1C on the same edge
  assign sel_n    = wr_ctrl ? HWDATA[2:1] : sel_q;
  assign irq_en_n = wr_ctrl ? HWDATA[3]   : irq_en_q;
  assign done_n   = finish_evt | (done_q & ~(wr_status & HWDATA[1]));
  assign ovr_n    = (start_req & busy) | (ovr_q & ~(wr_status & HWDATA[2]));

  // Address phase capture and software-visible registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      sel_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (HREADY) begin
        dp_valid <= HSEL & HTRANS[1];
        dp_write <= HWRITE;
        dp_addr  <= HADDR[3:2];
      end
      sel_q    <= sel_n;
      irq_en_q <= irq_en_n;
      done_q   <= done_n;
      ovr_q    <= ovr_n;
      irq_q    <= done_n & irq_en_n;
    end
  end

  // Play sequencer; ARM holds off until a stale finish from the last tune drops
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      cnt_q          <= '0;
      music_select_q <= '0;
      music_start_q  <= 1'b0;
    end else begin
      music_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state          <= ST_KICK;
            music_start_q  <= 1'b1;
            music_select_q <= sel_n;
          end
        end
        ST_KICK: state <= ST_ARM;
        ST_ARM: begin
          if (!music_finish) state <= ST_PLAY;
        end
        ST_PLAY: begin
          if (music_finish) begin
            state <= ST_IDLE;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (dp_addr)
      A_CTRL:    rd_data = DATA_W'({irq_en_q, sel_q, 1'b0});
      A_STATUS:  rd_data = DATA_W'({ovr_q, done_q, busy});
      A_PLAYCNT: rd_data = DATA_W'(cnt_q);
      default:   rd_data = '0;
    endcase
  end

  assign HRDATA = (dp_valid & ~dp_write) ? rd_data : '0;

endmodule

// File: tb/tb_ahb_buzzer_ctrl.sv
// Self-checking bench for ahb_buzzer_ctrl: directed scenarios plus randomized
// bus and tune traffic compared against a register-level reference model.
module tb_ahb_buzzer_ctrl;

  localparam int unsigned ADDR_W = 12;

  logic              clk;
  logic              rstn;
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [1:0]        music_select;
  logic              music_start;
  logic              music_finish;
  logic              irq;

  ahb_buzzer_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .music_select(music_select), .music_start(music_start),
    .music_finish(music_finish), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what software should observe
  bit       m_busy;
  bit [1:0] m_sel;
  bit [1:0] m_lat;
  bit       m_irq_en;
  bit       m_done;
  bit       m_ovr;
  bit [7:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_sel = 0; m_lat = 0; m_irq_en = 0;
    m_done = 0; m_ovr = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_irq_en, m_sel, 1'b0};
      2'd1:    return {29'd0, m_ovr, m_done, m_busy};
      2'd2:    return {24'd0, m_cnt};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_write(input logic [1:0] a, input logic [31:0] d, output bit acc);
    acc = 0;
    if (a == 2'd0) begin
      m_sel    = d[2:1];
      m_irq_en = d[3];
      if (d[0]) begin
        if (m_busy) m_ovr = 1;
        else begin
          m_busy = 1;
          m_lat  = d[2:1];
          acc    = 1;
        end
      end
    end else if (a == 2'd1) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_ovr  = 0;
    end
  endtask

  task automatic m_finish();
    if (m_busy) begin
      m_busy = 0;
      m_done = 1;
      m_cnt  = m_cnt + 8'd1;
    end
  endtask

  // One write transfer; returns on the falling edge after the commit edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                           input bit valid, input bit fin_same);
    logic [ADDR_W-1:0] ad;
    ad = ADDR_W'($urandom);
    ad[3:2] = a;
    @(negedge clk);
    HADDR  = ad;
    HWRITE = 1'b1;
    HSIZE  = 3'($urandom_range(0, 2));
    if (valid) begin
      HSEL   = 1'b1;
      HTRANS = {1'b1, 1'($urandom_range(0, 1))};
    end else if ($urandom_range(0, 1) == 1) begin
      HSEL   = 1'b0;
      HTRANS = {1'b1, 1'($urandom_range(0, 1))};
    end else begin
      HSEL   = 1'b1;
      HTRANS = {1'b0, 1'($urandom_range(0, 1))};
    end
    @(negedge clk);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = d;
    if (fin_same) music_finish = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    logic [ADDR_W-1:0] ad;
    ad = ADDR_W'($urandom);
    ad[3:2] = a;
    @(negedge clk);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = ad;
    @(negedge clk);
    d      = HRDATA;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, output bit acc);
    bus_write(a, d, 1'b1, 1'b0);
    m_write(a, d, acc);
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a);
    logic [31:0] d;
    bus_read(a, d);
    check_eq(tag, d, m_read(a));
  endtask

  // Let a running tune reach PLAY, then end it; optionally leave finish stuck high
  task automatic complete_tune(input bit stale);
    music_finish = 1'b0;
    repeat (3) @(negedge clk);
    music_finish = 1'b1;
    @(negedge clk);
    m_finish();
    check_eq("irq_after_finish", irq, m_done & m_irq_en);
    music_finish = stale;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    music_finish = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_reset();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int pulses;
    HADDR = '0; HWDATA = '0; HSIZE = 3'd2; HREADY = 1'b1;
    do_reset();

    check_eq("rst_hreadyout", HREADYOUT, 1);
    check_eq("rst_hresp", HRESP, 0);
    check_eq("rst_hrdata", HRDATA, 0);
    check_eq("rst_select", music_select, 0);
    check_eq("rst_start", music_start, 0);
    check_eq("rst_irq", irq, 0);

    // Launch tune 2 with a stale finish still high from the player
    music_finish = 1'b1;
    wr(2'd0, 32'h5, acc);
    check_eq("kick_start", music_start, 1);
    check_eq("kick_select", music_select, 2);
    @(negedge clk);
    check_eq("kick_one_cycle", music_start, 0);
    rd_check("status_busy", 2'd1);
    repeat (10) @(negedge clk);
    rd_check("stale_finish_ignored", 2'd1);
    music_finish = 1'b0;
    repeat (50) @(negedge clk);
    rd_check("still_playing", 2'd1);
    music_finish = 1'b1;
    @(negedge clk);
    m_finish();
    music_finish = 1'b0;
    rd_check("status_done", 2'd1);
    rd_check("playcnt_one", 2'd2);
    rd_check("ctrl_readback", 2'd0);

    // Interrupt enable and W1C clear
    wr(2'd0, 32'h8, acc);
    check_eq("irq_enabled", irq, 1);
    wr(2'd1, 32'h2, acc);
    check_eq("irq_cleared", irq, 0);
    wr(2'd0, 32'h9, acc);
    check_eq("irq_tune_start", music_start, acc);
    complete_tune(1'b0);
    wr(2'd1, 32'h2, acc);

    // Overrun on START while busy
    wr(2'd0, 32'h3, acc);
    check_eq("ovr_first_start", music_start, 1);
    wr(2'd0, 32'h1, acc);
    check_eq("ovr_no_pulse", music_start, 0);
    check_eq("ovr_select_held", music_select, m_lat);
    rd_check("status_ovr", 2'd1);
    wr(2'd1, 32'h4, acc);
    rd_check("ovr_w1c", 2'd1);
    wr(2'd0, 32'h1, acc);
    music_finish = 1'b0;
    repeat (3) @(negedge clk);
    // Finish lands on the same edge as a DONE clear: set must win
    bus_write(2'd1, 32'h2, 1'b1, 1'b1);
    m_write(2'd1, 32'h2, acc);
    m_finish();
    music_finish = 1'b0;
    rd_check("done_set_wins", 2'd1);
    wr(2'd1, 32'h6, acc);
    rd_check("status_all_clear", 2'd1);

    // Reserved and read-only locations
    wr(2'd3, 32'hFFFF_FFFF, acc);
    rd_check("reserved_raz", 2'd3);
    wr(2'd2, 32'h0000_00A5, acc);
    rd_check("playcnt_ro", 2'd2);

    // Counter wrap after 256 tunes
    do_reset();
    for (int i = 0; i < 256; i++) begin
      wr(2'd0, 32'($urandom_range(0, 7) << 1) | 32'h1, acc);
      if (!acc || music_start !== 1'b1) check_eq("wrap_start", music_start, acc);
      complete_tune(1'b0);
    end
    rd_check("playcnt_wrap", 2'd2);
    check_eq("playcnt_model_zero", m_cnt, 0);

    // Reset in the middle of a tune
    wr(2'd0, 32'hF, acc);
    music_finish = 1'b0;
    repeat (5) @(negedge clk);
    do_reset();
    check_eq("midrst_select", music_select, 0);
    check_eq("midrst_irq", irq, 0);
    rd_check("midrst_ctrl", 2'd0);
    rd_check("midrst_status", 2'd1);
    rd_check("midrst_cnt", 2'd2);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      music_finish = (i == 8);
      @(negedge clk);
      if (music_start) pulses++;
    end
    check_eq("midrst_no_start", pulses, 0);
    music_finish = 1'b0;

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int act;
      logic [31:0] d;
      logic [1:0]  a;
      act = $urandom_range(0, 9);
      d   = $urandom;
      a   = 2'($urandom_range(0, 3));
      case (act)
        0, 1, 2: begin
          wr(2'd0, d, acc);
          check_eq("rnd_start", music_start, acc);
          if (acc) check_eq("rnd_select", music_select, m_lat);
        end
        3: wr(2'd1, d, acc);
        4: wr(2'($urandom_range(2, 3)), d, acc);
        5: begin
          bus_write(a, d | 32'h1, 1'b0, 1'b0);
          check_eq("rnd_ignored_xfer", music_start, 0);
        end
        6, 7: rd_check("rnd_read", a);
        8: complete_tune(1'($urandom_range(0, 1)));
        default: begin
          repeat ($urandom_range(1, 5)) @(negedge clk);
          check_eq("rnd_idle_start", music_start, 0);
          check_eq("rnd_idle_select", music_select, m_lat);
          check_eq("rnd_idle_irq", irq, m_done & m_irq_en);
          check_eq("rnd_idle_hrdata", HRDATA, 0);
          check_eq("rnd_idle_resp", {HREADYOUT, HRESP}, 2'b10);
        end
      endcase
    end
    rd_check("final_status", 2'd1);
    rd_check("final_cnt", 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
